// File: rtl/id_regs.sv
// Identification/status register bank on the CPU native bus: read-only ID and
// VERSION, byte-writable SCRATCH, and an uptime counter with coherent LO/HI readback.
module id_regs #(
   parameter int unsigned       DATA_W  = 32,
   parameter int unsigned       ADDR_W  = 3,
   parameter logic [DATA_W-1:0] ID      = '0,
   parameter logic [DATA_W-1:0] VERSION = DATA_W'(1),
   parameter int unsigned       CNT_W   = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned HI_W   = CNT_W - DATA_W;

   localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(5);

   logic [DATA_W-1:0] r_rdata;
   logic              r_ready;
   logic [DATA_W-1:0] r_scratch;
   logic [CNT_W-1:0]  r_cnt;
   logic [HI_W-1:0]   r_hi;
   logic              r_freeze;

   logic              w_accept;
   logic              w_write;
   logic              w_ctrl_wr;
   logic              w_clear;
   logic              w_lo_rd;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_scratch_nxt;

   // A request is taken only while ready is low, giving one access per two cycles.
   assign w_accept  = valid & ~r_ready;
   assign w_write   = |wstrb;
   assign w_ctrl_wr = w_accept & w_write & (address == A_CTRL) & wstrb[0];
   assign w_clear   = w_ctrl_wr & wdata[0];
   assign w_lo_rd   = w_accept & ~w_write & (address == A_UP_LO);

   always_comb begin
      // NOTE: default assigned first so no path leaves w_rd_data unassigned (no latch).
      w_rd_data = '0;
      case (address)
         A_ID:      w_rd_data = ID;
         A_VERSION: w_rd_data = VERSION;
         A_SCRATCH: w_rd_data = r_scratch;
         A_UP_LO:   w_rd_data = r_cnt[DATA_W-1:0];
         A_UP_HI:   w_rd_data = DATA_W'(r_hi);
         A_CTRL:    w_rd_data = DATA_W'({r_freeze, 1'b0});
         default:   w_rd_data = '0;
      endcase
   end

   always_comb begin
      w_scratch_nxt = r_scratch;
      for (int i = 0; i < STRB_W; i++) begin
         if (wstrb[i]) w_scratch_nxt[8*i +: 8] = wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready   <= 1'b0;
         r_rdata   <= '0;
         r_scratch <= '0;
         r_freeze  <= 1'b0;
         r_hi      <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of its peers.
         r_ready <= w_accept;
         if (w_accept) r_rdata <= w_rd_data;
         if (w_accept && w_write && (address == A_SCRATCH)) r_scratch <= w_scratch_nxt;
         if (w_ctrl_wr) r_freeze <= wdata[1];
         // HI shadow comes from the same pre-edge sample as the LO word.
         if (w_lo_rd) r_hi <= r_cnt[CNT_W-1:DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_clear) begin
         r_cnt <= '0;
      end else if (!r_freeze) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign rdata = r_rdata;
   assign ready = r_ready;

endmodule

// File: tb/tb_id_regs.sv
// Directed bench for id_regs: expected read data queued at request time and
// compared when the ready pulse arrives.
module tb_id_regs;
   localparam int DW = 32;
   localparam int AW = 3;
   localparam int CW = 64;
   localparam logic [DW-1:0] P_ID  = 32'h0000_001D;
   localparam logic [DW-1:0] P_VER = 32'h0001_0203;

   typedef struct {
      logic          chk;
      logic [DW-1:0] val;
      string         tag;
   } exp_t;

   logic            clk     = 1'b0;
   logic            rst_n   = 1'b0;
   logic            valid   = 1'b0;
   logic [AW-1:0]   address = '0;
   logic [DW-1:0]   wdata   = '0;
   logic [DW/8-1:0] wstrb   = '0;
   logic [DW-1:0]   rdata;
   logic            ready;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb[$];

   id_regs #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .ID     (P_ID),
      .VERSION(P_VER),
      .CNT_W  (CW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (valid),
      .address(address),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .rdata  (rdata),
      .ready  (ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with ready low; returns at a negedge with ready low.
   task automatic access(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW/8-1:0] s, input logic chk,
                         input logic [DW-1:0] exp, input string tag, output int acc);
      exp_t e;
      int   n;
      valid   = 1'b1;
      address = a;
      wdata   = d;
      wstrb   = s;
      acc     = cyc + 1;
      sb.push_back('{chk: chk, val: exp, tag: tag});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 8);
      if (!ready) begin
         check({tag, "_timeout"}, ready, 1);
         sb.delete();
      end else begin
         e = sb.pop_front();
         if (e.chk) check(e.tag, rdata, e.val);
      end
      valid = 1'b0;
      wstrb = '0;
      @(negedge clk);
      check({tag, "_pulse"}, ready, 0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
      int acc;
      access(a, '0, '0, 1'b1, exp, tag, acc);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW/8-1:0] s, input string tag);
      int acc;
      access(a, d, s, 1'b0, '0, tag, acc);
   endtask

   initial begin
      int            c0;
      int            acc;
      int            pulses;
      logic [DW-1:0] v;
      exp_t          e;

      // Reset with the bus idle, then release.
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_rdata", rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ready", ready, 0);
      check("rel_rdata", rdata, 0);

      rd(3'd0, P_ID, "id");

      // SCRATCH byte lanes and RO write protection.
      wr(3'd2, 32'hA5A5_A5A5, 4'hF, "scr_full");
      wr(3'd2, 32'h1234_5678, 4'h3, "scr_low2");
      rd(3'd2, 32'hA5A5_5678, "scr_merge");
      wr(3'd1, 32'hFFFF_FFFF, 4'hF, "ver_wr");
      rd(3'd1, P_VER, "version");
      wr(3'd7, 32'hFFFF_FFFF, 4'hF, "a7_wr");
      rd(3'd7, 32'h0, "a7_rd");
      rd(3'd6, 32'h0, "a6_rd");

      // Clear + freeze holds at zero; release freeze and count from zero.
      wr(3'd5, 32'h3, 4'h1, "ctrl_clr_frz");
      rd(3'd3, 32'h0, "lo_frozen_a");
      rd(3'd3, 32'h0, "lo_frozen_b");
      rd(3'd4, 32'h0, "hi_frozen");
      rd(3'd5, 32'h2, "ctrl_rb");
      access(3'd5, 32'h0, 4'h1, 1'b0, '0, "ctrl_run", c0);
      rd(3'd5, 32'h0, "ctrl_rb_run");
      repeat (10) @(negedge clk);
      v = DW'(cyc - c0);
      rd(3'd3, v, "lo_run_a");
      v = DW'(cyc - c0);
      rd(3'd3, v, "lo_run_b");

      // valid held for 6 cycles: accepts on cycles 1, 3 and 5.
      valid   = 1'b1;
      address = 3'd3;
      wstrb   = '0;
      v       = DW'(cyc - c0);
      for (int k = 0; k < 3; k++) sb.push_back('{chk: 1'b1, val: v + DW'(2 * k), tag: "burst_lo"});
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ready) begin
            pulses++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check(e.tag, rdata, e.val);
            end
         end
      end
      valid = 1'b0;
      check("burst_pulses", pulses, 3);
      check("burst_sb_left", sb.size(), 0);
      @(negedge clk);

      // Carry coherence: LO sampled on the carry edge, HI from the same sample.
      force dut.r_cnt = 64'h0000_0000_FFFF_FFFF;
      #1 release dut.r_cnt;
      rd(3'd3, 32'hFFFF_FFFF, "lo_carry");
      check("live_hi", dut.r_cnt[63:32], 1);
      rd(3'd4, 32'h0, "hi_coherent");
      access(3'd3, '0, '0, 1'b0, '0, "lo_after", acc);
      rd(3'd4, 32'h1, "hi_after");

      // Asynchronous reset in the middle of a ready pulse.
      wr(3'd2, 32'hDEAD_BEEF, 4'hF, "scr_pre_rst");
      valid   = 1'b1;
      address = 3'd2;
      wstrb   = '0;
      @(negedge clk);
      check("pre_rst_ready", ready, 1);
      check("pre_rst_rdata", rdata, 32'hDEAD_BEEF);
      #1 rst_n = 1'b0;
      #1;
      check("arst_ready", ready, 0);
      check("arst_rdata", rdata, 0);
      check("arst_scratch", dut.r_scratch, 0);
      check("arst_cnt", dut.r_cnt, 0);
      valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd(3'd2, 32'h0, "scr_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
